camera_space_dot_sequencer: RTL and testbench



---
 rtl/camera_space_dot_sequencer_if.sv | 27 ++
 rtl/camera_space_dot_sequencer.sv | 67 ++++++
 tb/tb_camera_space_dot_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/camera_space_dot_sequencer_if.sv
// camera_space_dot_sequencer_if: request, dot-unit and result handshake bundle
interface camera_space_dot_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int D_WIDTH = 20
);
  logic                          in_valid;
  logic                          in_ready;
  logic [2:0][WIDTH-1:0]         in_point;
  logic [2:0][WIDTH-1:0]         cam_pos;
  logic [2:0][WIDTH-1:0]         basis_u;
  logic [2:0][WIDTH-1:0]         basis_v;
  logic [2:0][WIDTH-1:0]         basis_n;
  logic [2:0][WIDTH-1:0]         dot_a;
  logic [2:0][WIDTH-1:0]         dot_b;
  logic [D_WIDTH-1:0]            dot_d;
  logic                          out_valid;
  logic                          out_ready;
  logic [2:0][D_WIDTH-1:0]       out_vec;
  modport slave (
    input  in_valid, in_point, cam_pos, basis_u, basis_v, basis_n, dot_d, out_ready,
    output in_ready, dot_a, dot_b, out_valid, out_vec
  );
  modport master (
    output in_valid, in_point, cam_pos, basis_u, basis_v, basis_n, dot_d, out_ready,
    input  in_ready, dot_a, dot_b, out_valid, out_vec
  );
endinterface

// File: rtl/camera_space_dot_sequencer.sv
// camera_space_dot_sequencer: saturating point-minus-camera, three dot issues, result collection
module camera_space_dot_sequencer #(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 14,
  parameter int D_WIDTH     = 20,
  parameter int DOT_LATENCY = 3
) (
  input logic clk_in,
  input logic rst_in,
  camera_space_dot_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, DRAIN, HOLD} state_t;
  state_t                        state_q;
  logic [2:0][WIDTH-1:0]         rel_d, rel_q, bu_q, bv_q, bn_q;
  logic [2:0][WIDTH:0]           diff;
  logic [DOT_LATENCY-1:0][2:0]   tag_q;
  logic [2:0][D_WIDTH-1:0]       res_q;
  logic                          issue;
  logic [2:0]                    tag_in, tag_out;
  if (FRAC_BITS >= WIDTH) begin : g_frac_check
    $error("FRAC_BITS must be below WIDTH");
  end
  for (genvar i = 0; i < 3; i++) begin : g_sub
    assign diff[i] = {bus.in_point[i][WIDTH-1], bus.in_point[i]} - {bus.cam_pos[i][WIDTH-1], bus.cam_pos[i]};
    assign rel_d[i] = (diff[i][WIDTH] == diff[i][WIDTH-1]) ? diff[i][WIDTH-1:0]
                    : {diff[i][WIDTH], {(WIDTH-1){~diff[i][WIDTH]}}};
  end
  assign issue   = (state_q == ISSUE0) || (state_q == ISSUE1) || (state_q == ISSUE2);
  assign tag_in  = {issue, state_q == ISSUE2, state_q == ISSUE1};
  assign tag_out = tag_q[DOT_LATENCY-1];
  assign bus.in_ready  = (state_q == IDLE) && !rst_in;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_vec   = res_q;
  assign bus.dot_a     = issue ? rel_q : '0;
  assign bus.dot_b     = (state_q == ISSUE0) ? bu_q : (state_q == ISSUE1) ? bv_q
                       : (state_q == ISSUE2) ? bn_q : '0;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rel_q   <= '0;
      bu_q    <= '0;
      bv_q    <= '0;
      bn_q    <= '0;
      tag_q   <= '0;
      res_q   <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < DOT_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (tag_out[2]) res_q[tag_out[1:0]] <= bus.dot_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          rel_q   <= rel_d;
          bu_q    <= bus.basis_u;
          bv_q    <= bus.basis_v;
          bn_q    <= bus.basis_n;
          state_q <= ISSUE0;
        end
        ISSUE0:  state_q <= ISSUE1;
        ISSUE1:  state_q <= ISSUE2;
        ISSUE2:  state_q <= DRAIN;
        DRAIN:   if (tag_out == 3'b110) state_q <= HOLD;
        HOLD:    if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_camera_space_dot_sequencer.sv
// tb_camera_space_dot_sequencer: directed checks with a behavioural 3-cycle dot unit
module tb_camera_space_dot_sequencer;
  logic clk = 0;
  logic rst = 1;
  int   passed = 0;
  int   total = 0;
  logic [19:0] p1 = '0, p2 = '0, p3 = '0;
  always #5 clk = ~clk;
  camera_space_dot_sequencer_if bus ();
  camera_space_dot_sequencer dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  function automatic logic [19:0] dot3(logic [2:0][15:0] a, logic [2:0][15:0] b);
    longint s = 0;
    for (int i = 0; i < 3; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
    return 20'(s >>> 14);
  endfunction
  always @(posedge clk) begin
    p1 <= dot3(bus.dot_a, bus.dot_b);
    p2 <= p1;
    p3 <= p2;
  end
  assign bus.dot_d = p3;
  function automatic logic [2:0][15:0] vec(int x, int y, int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction
  function automatic logic [59:0] ev(int x, int y, int z);
    return {20'(z), 20'(y), 20'(x)};
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_txn(string tag, logic [2:0][15:0] p, logic [2:0][15:0] c,
                         logic [2:0][15:0] u, logic [2:0][15:0] v, logic [2:0][15:0] n,
                         logic [2:0][15:0] rel, logic [59:0] e, int hold);
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_point = p; bus.cam_pos = c;
    bus.basis_u = u; bus.basis_v = v; bus.basis_n = n;
    bus.in_valid = 1;
    bus.out_ready = (hold == 0);
    step();
    bus.in_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      chk({tag, "_early_valid"}, 64'(bus.out_valid), 64'(0));
      if (k == 1) chk({tag, "_dot_a"}, 64'(bus.dot_a), 64'(rel));
      if (k == 1) chk({tag, "_dot_b_u"}, 64'(bus.dot_b), 64'(u));
      if (k == 2) chk({tag, "_dot_b_v"}, 64'(bus.dot_b), 64'(v));
      if (k == 3) chk({tag, "_dot_b_n"}, 64'(bus.dot_b), 64'(n));
      if (k == 4) chk({tag, "_dot_idle"}, 64'(bus.dot_a), 64'(0));
      step();
    end
    chk({tag, "_valid7"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_vec"}, 64'(bus.out_vec), 64'(e));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_bp_valid"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_bp_vec"}, 64'(bus.out_vec), 64'(e));
      chk({tag, "_bp_ready"}, 64'(bus.in_ready), 64'(0));
      chk({tag, "_bp_dot"}, 64'({bus.dot_a, bus.dot_b}), 64'(0));
    end
    bus.out_ready = 1;
    step();
    chk({tag, "_done_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_done_ready"}, 64'(bus.in_ready), 64'(1));
  endtask
  initial begin
    bus.in_valid = 0; bus.out_ready = 1;
    bus.in_point = '0; bus.cam_pos = '0;
    bus.basis_u = '0; bus.basis_v = '0; bus.basis_n = '0;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_vec", 64'(bus.out_vec), 64'(0));
    chk("rst_dot", 64'({bus.dot_a, bus.dot_b}), 64'(0));
    @(negedge clk);
    rst = 0;
    #1;
    chk("release_ready", 64'(bus.in_ready), 64'(1));
    step();
    run_txn("ident", vec(8192, 4096, -4096), vec(0, 0, 0),
            vec(16384, 0, 0), vec(0, 16384, 0), vec(0, 0, 16384),
            vec(8192, 4096, -4096), ev(8192, 4096, -4096), 0);
    run_txn("sat", vec(31130, -30000, 0), vec(-16384, 16384, 0),
            vec(16384, 0, 0), vec(0, 16384, 0), vec(0, 0, 16384),
            vec(32767, -32768, 0), ev(32767, -32768, 0), 0);
    run_txn("swap", vec(8192, 4096, 4096), vec(0, 0, 0),
            vec(0, 16384, 0), vec(16384, 0, 0), vec(0, 0, -16384),
            vec(8192, 4096, 4096), ev(4096, 8192, -4096), 0);
    run_txn("bp", vec(-2048, 1024, 512), vec(1024, 0, -512),
            vec(16384, 0, 0), vec(0, 16384, 0), vec(0, 0, 16384),
            vec(-3072, 1024, 1024), ev(-3072, 1024, 1024), 10);
    // abort with two results still inside the dot pipeline
    bus.in_point = vec(8192, 4096, -4096); bus.cam_pos = '0;
    bus.basis_u = vec(16384, 0, 0); bus.basis_v = vec(0, 16384, 0); bus.basis_n = vec(0, 0, 16384);
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    step();
    step();
    chk("mid_dot_busy", 64'(bus.dot_a != '0), 64'(1));
    rst = 1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_ready", 64'(bus.in_ready), 64'(0));
    chk("mid_rst_dot", 64'({bus.dot_a, bus.dot_b}), 64'(0));
    @(negedge clk);
    rst = 0;
    step();
    for (int k = 0; k < 10; k++) chk("post_rst_valid", 64'(bus.out_valid), 64'(0));
    for (int k = 0; k < 10; k++) step();
    chk("post_rst_vec", 64'(bus.out_vec), 64'(0));
    run_txn("after_rst", vec(8192, 4096, 4096), vec(0, 0, 0),
            vec(0, 16384, 0), vec(16384, 0, 0), vec(0, 0, -16384),
            vec(8192, 4096, 4096), ev(4096, 8192, -4096), 0);
    bus.in_point = vec(1000, 2000, 3000); bus.cam_pos = '0;
    bus.basis_u = vec(16384, 0, 0); bus.basis_v = vec(0, 16384, 0); bus.basis_n = vec(0, 0, 16384);
    bus.in_valid = 1; bus.out_ready = 1;
    step();
    bus.in_point = vec(-5000, 6000, -7000);
    for (int k = 0; k < 6; k++) step();
    chk("b2b_valid7", 64'(bus.out_valid), 64'(1));
    chk("b2b_vec_a", 64'(bus.out_vec), 64'(ev(1000, 2000, 3000)));
    step();
    chk("b2b_ready8", 64'(bus.in_ready), 64'(1));
    for (int k = 0; k < 6; k++) step();
    chk("b2b_valid14", 64'(bus.out_valid), 64'(0));
    step();
    bus.in_valid = 0;
    chk("b2b_valid15", 64'(bus.out_valid), 64'(1));
    chk("b2b_vec_b", 64'(bus.out_vec), 64'(ev(-5000, 6000, -7000)));
    step();
    chk("b2b_done", 64'(bus.out_valid), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
